motion_bbox_tracker: RTL and testbench

MOTION_BBOX_TRACKER -- requirements
Module: motion_bbox_tracker

---
 rtl/motion_bbox_tracker.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_motion_bbox_tracker.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/motion_bbox_tracker.sv
// motion_bbox_tracker
// Accumulates the bounding box and count of motion pixels over a raster
// frame and latches them at frame end. A frame starts at pixel (0,0) and
// ends at pixel (X_MAX,Y_MAX). Pixels arrive sparsely, qualified by pix_en.
// The results are registered and appear one cycle after the frame-end pixel.
// The outline drawer is optional. Define MOTION_BBOX_DRAW_EN to build it.
// Without that macro, draw_plot, draw_x and draw_y are held at zero.
module motion_bbox_tracker #(
  parameter int X_MAX  = 319,
  parameter int Y_MAX  = 239,
  parameter int THRESH = 64
) (
  input  logic        CLOCK_50,
  input  logic        resetn,
  input  logic        pix_en,
  input  logic [8:0]  pix_x,
  input  logic [7:0]  pix_y,
  input  logic        pix_motion,
  output logic        frame_done,
  output logic        motion_valid,
  output logic [8:0]  bbox_xmin,
  output logic [8:0]  bbox_xmax,
  output logic [7:0]  bbox_ymin,
  output logic [7:0]  bbox_ymax,
  output logic [16:0] motion_count,
  output logic [8:0]  draw_x,
  output logic [7:0]  draw_y,
  output logic        draw_plot
);

  localparam logic [8:0]  X_MAX_C  = 9'(X_MAX);
  localparam logic [7:0]  Y_MAX_C  = 8'(Y_MAX);
  localparam logic [16:0] THRESH_C = 17'(THRESH);
  localparam logic [16:0] CNT_SAT  = 17'h1FFFF;

  function automatic logic [8:0] min9(input logic [8:0] a, input logic [8:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [8:0] max9(input logic [8:0] a, input logic [8:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [7:0] min8(input logic [7:0] a, input logic [7:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [7:0] max8(input logic [7:0] a, input logic [7:0] b);
    return (a > b) ? a : b;
  endfunction

  // running accumulators
  logic [8:0]  xmin_r, xmax_r;
  logic [7:0]  ymin_r, ymax_r;
  logic [16:0] count_r;

  // next-state values of the accumulators
  logic [8:0]  xmin_s, xmax_s;
  logic [7:0]  ymin_s, ymax_s;
  logic [16:0] count_s;

  logic accept_s;
  logic start_s;
  logic end_s;

  // latched result registers
  logic        frame_done_r;
  logic        motion_valid_r;
  logic [8:0]  bbox_xmin_r, bbox_xmax_r;
  logic [7:0]  bbox_ymin_r, bbox_ymax_r;
  logic [16:0] motion_count_r;

  assign accept_s = pix_en && (pix_x <= X_MAX_C) && (pix_y <= Y_MAX_C);
  assign start_s  = accept_s && (pix_x == 9'd0) && (pix_y == 8'd0);
  assign end_s    = accept_s && (pix_x == X_MAX_C) && (pix_y == Y_MAX_C);

  // Next accumulator values. The frame-start pixel clears, then accumulates.
  always_comb begin
    xmin_s  = xmin_r;
    xmax_s  = xmax_r;
    ymin_s  = ymin_r;
    ymax_s  = ymax_r;
    count_s = count_r;
    if (start_s) begin
      xmin_s  = X_MAX_C;
      xmax_s  = 9'd0;
      ymin_s  = Y_MAX_C;
      ymax_s  = 8'd0;
      count_s = 17'd0;
    end else begin
      xmin_s  = xmin_r;
    end
    if (accept_s && pix_motion) begin
      xmin_s = min9(xmin_s, pix_x);
      xmax_s = max9(xmax_s, pix_x);
      ymin_s = min8(ymin_s, pix_y);
      ymax_s = max8(ymax_s, pix_y);
      if (count_s != CNT_SAT) begin
        count_s = count_s + 17'd1;
      end else begin
        count_s = CNT_SAT;
      end
    end else begin
      count_s = count_s;
    end
  end

  // Accumulator registers. They are cleared after frame end so that the next
  // frame starts clean even if it has no (0,0) pixel.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      xmin_r  <= X_MAX_C;
      xmax_r  <= 9'd0;
      ymin_r  <= Y_MAX_C;
      ymax_r  <= 8'd0;
      count_r <= 17'd0;
    end else if (end_s) begin
      xmin_r  <= X_MAX_C;
      xmax_r  <= 9'd0;
      ymin_r  <= Y_MAX_C;
      ymax_r  <= 8'd0;
      count_r <= 17'd0;
    end else begin
      xmin_r  <= xmin_s;
      xmax_r  <= xmax_s;
      ymin_r  <= ymin_s;
      ymax_r  <= ymax_s;
      count_r <= count_s;
    end
  end

  // Result latch. The totals include the frame-end pixel itself. The box is
  // updated only when the frame meets THRESH.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      frame_done_r   <= 1'b0;
      motion_valid_r <= 1'b0;
      motion_count_r <= 17'd0;
      bbox_xmin_r    <= 9'd0;
      bbox_xmax_r    <= 9'd0;
      bbox_ymin_r    <= 8'd0;
      bbox_ymax_r    <= 8'd0;
    end else if (end_s) begin
      frame_done_r   <= 1'b1;
      motion_count_r <= count_s;
      motion_valid_r <= (count_s >= THRESH_C);
      if (count_s >= THRESH_C) begin
        bbox_xmin_r <= xmin_s;
        bbox_xmax_r <= xmax_s;
        bbox_ymin_r <= ymin_s;
        bbox_ymax_r <= ymax_s;
      end else begin
        bbox_xmin_r <= bbox_xmin_r;
        bbox_xmax_r <= bbox_xmax_r;
        bbox_ymin_r <= bbox_ymin_r;
        bbox_ymax_r <= bbox_ymax_r;
      end
    end else begin
      frame_done_r <= 1'b0;
    end
  end

  assign frame_done   = frame_done_r;
  assign motion_valid = motion_valid_r;
  assign motion_count = motion_count_r;
  assign bbox_xmin    = bbox_xmin_r;
  assign bbox_xmax    = bbox_xmax_r;
  assign bbox_ymin    = bbox_ymin_r;
  assign bbox_ymax    = bbox_ymax_r;

`ifdef MOTION_BBOX_DRAW_EN

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_TOP    = 3'd1,
    ST_BOTTOM = 3'd2,
    ST_LEFT   = 3'd3,
    ST_RIGHT  = 3'd4
  } draw_state_t;

  draw_state_t draw_state_r, draw_state_s;
  logic [8:0]  draw_x_r, draw_x_s;
  logic [7:0]  draw_y_r, draw_y_s;
  logic        draw_plot_r, draw_plot_s;
  logic        draw_start_s;

  assign draw_start_s = frame_done_r && motion_valid_r;

  // Drawer state and point registers. The point registers drive the outputs.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      draw_state_r <= ST_IDLE;
      draw_x_r     <= 9'd0;
      draw_y_r     <= 8'd0;
      draw_plot_r  <= 1'b0;
    end else begin
      draw_state_r <= draw_state_s;
      draw_x_r     <= draw_x_s;
      draw_y_r     <= draw_y_s;
      draw_plot_r  <= draw_plot_s;
    end
  end

  // Outline walk: top edge, bottom edge, left edge, then right edge.
  // A new valid box restarts the walk at the top edge. Edge ends use >= so a
  // degenerate box cannot make the walk run away.
  always_comb begin
    draw_state_s = draw_state_r;
    draw_x_s     = draw_x_r;
    draw_y_s     = draw_y_r;
    draw_plot_s  = 1'b1;
    if (draw_start_s) begin
      draw_state_s = ST_TOP;
      draw_x_s     = bbox_xmin_r;
      draw_y_s     = bbox_ymin_r;
    end else begin
      case (draw_state_r)
        ST_IDLE: begin
          draw_state_s = ST_IDLE;
          draw_x_s     = 9'd0;
          draw_y_s     = 8'd0;
          draw_plot_s  = 1'b0;
        end
        ST_TOP: begin
          if (draw_x_r >= bbox_xmax_r) begin
            draw_state_s = ST_BOTTOM;
            draw_x_s     = bbox_xmin_r;
            draw_y_s     = bbox_ymax_r;
          end else begin
            draw_x_s     = draw_x_r + 9'd1;
          end
        end
        ST_BOTTOM: begin
          if (draw_x_r >= bbox_xmax_r) begin
            draw_state_s = ST_LEFT;
            draw_x_s     = bbox_xmin_r;
            draw_y_s     = bbox_ymin_r;
          end else begin
            draw_x_s     = draw_x_r + 9'd1;
          end
        end
        ST_LEFT: begin
          if (draw_y_r >= bbox_ymax_r) begin
            draw_state_s = ST_RIGHT;
            draw_x_s     = bbox_xmax_r;
            draw_y_s     = bbox_ymin_r;
          end else begin
            draw_y_s     = draw_y_r + 8'd1;
          end
        end
        ST_RIGHT: begin
          if (draw_y_r >= bbox_ymax_r) begin
            draw_state_s = ST_IDLE;
            draw_x_s     = 9'd0;
            draw_y_s     = 8'd0;
            draw_plot_s  = 1'b0;
          end else begin
            draw_y_s     = draw_y_r + 8'd1;
          end
        end
        default: begin
          draw_state_s = ST_IDLE;
          draw_x_s     = 9'd0;
          draw_y_s     = 8'd0;
          draw_plot_s  = 1'b0;
        end
      endcase
    end
  end

  assign draw_x    = draw_x_r;
  assign draw_y    = draw_y_r;
  assign draw_plot = draw_plot_r;

`else

  assign draw_x    = 9'd0;
  assign draw_y    = 8'd0;
  assign draw_plot = 1'b0;

`endif

endmodule

// File: tb/tb_motion_bbox_tracker.sv
// Directed testbench for motion_bbox_tracker.
// Frames are sent sparsely. Each frame is a (0,0) pixel, a few motion pixels,
// and the (319,239) end pixel. Inputs change and outputs are sampled on the
// falling edge.
module tb_motion_bbox_tracker;

  logic        CLOCK_50;
  logic        resetn;
  logic        pix_en;
  logic [8:0]  pix_x;
  logic [7:0]  pix_y;
  logic        pix_motion;
  logic        frame_done;
  logic        motion_valid;
  logic [8:0]  bbox_xmin, bbox_xmax;
  logic [7:0]  bbox_ymin, bbox_ymax;
  logic [16:0] motion_count;
  logic [8:0]  draw_x;
  logic [7:0]  draw_y;
  logic        draw_plot;

  int checks = 0;
  int errors = 0;
  int fd_cnt = 0;
  int dp_cnt = 0;
  int fd_base;

  motion_bbox_tracker #(.X_MAX(319), .Y_MAX(239), .THRESH(2)) dut (
    .CLOCK_50     (CLOCK_50),
    .resetn       (resetn),
    .pix_en       (pix_en),
    .pix_x        (pix_x),
    .pix_y        (pix_y),
    .pix_motion   (pix_motion),
    .frame_done   (frame_done),
    .motion_valid (motion_valid),
    .bbox_xmin    (bbox_xmin),
    .bbox_xmax    (bbox_xmax),
    .bbox_ymin    (bbox_ymin),
    .bbox_ymax    (bbox_ymax),
    .motion_count (motion_count),
    .draw_x       (draw_x),
    .draw_y       (draw_y),
    .draw_plot    (draw_plot)
  );

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  always @(negedge CLOCK_50) begin
    if (frame_done === 1'b1) fd_cnt++;
    if (draw_plot === 1'b1) dp_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One accepted-pixel cycle. Call and return on a falling edge.
  task automatic pix(input logic [8:0] x, input logic [7:0] y, input logic m);
    pix_en = 1'b1; pix_x = x; pix_y = y; pix_motion = m;
    @(negedge CLOCK_50);
    pix_en = 1'b0; pix_motion = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge CLOCK_50);
  endtask

  task automatic chk_box(input string tag, input logic [8:0] x0, input logic [8:0] x1,
                         input logic [7:0] y0, input logic [7:0] y1);
    chk({tag, "_xmin"}, 32'(bbox_xmin), 32'(x0));
    chk({tag, "_xmax"}, 32'(bbox_xmax), 32'(x1));
    chk({tag, "_ymin"}, 32'(bbox_ymin), 32'(y0));
    chk({tag, "_ymax"}, 32'(bbox_ymax), 32'(y1));
  endtask

`ifdef MOTION_BBOX_DRAW_EN
  logic [8:0] exp_dx [10] = '{9'd5, 9'd6, 9'd7, 9'd5, 9'd6, 9'd7, 9'd5, 9'd5, 9'd7, 9'd7};
  logic [7:0] exp_dy [10] = '{8'd2, 8'd2, 8'd2, 8'd3, 8'd3, 8'd3, 8'd2, 8'd3, 8'd2, 8'd3};
`endif

  initial begin
    resetn = 1'b0; pix_en = 1'b0; pix_x = 9'd0; pix_y = 8'd0; pix_motion = 1'b0;
    idle(3);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_valid", 32'(motion_valid), 32'd0);
    chk("rst_count", 32'(motion_count), 32'd0);
    chk_box("rst", 9'd0, 9'd0, 8'd0, 8'd0);
    chk("rst_draw_plot", 32'(draw_plot), 32'd0);
    chk("rst_draw_x", 32'(draw_x), 32'd0);
    chk("rst_draw_y", 32'(draw_y), 32'd0);
    resetn = 1'b1;
    idle(2);

    // Two motion pixels form box 10..100 x 20..50.
    pix(9'd0, 8'd0, 1'b0);
    pix(9'd10, 8'd20, 1'b1);
    pix(9'd100, 8'd50, 1'b1);
    pix(9'd200, 8'd30, 1'b0);
    chk("f1_no_early_done", 32'(frame_done), 32'd0);
    pix(9'd319, 8'd239, 1'b0);
    chk("f1_frame_done", 32'(frame_done), 32'd1);
    chk("f1_count", 32'(motion_count), 32'd2);
    chk("f1_valid", 32'(motion_valid), 32'd1);
    chk_box("f1", 9'd10, 9'd100, 8'd20, 8'd50);
    idle(1);
    chk("f1_done_one_cycle", 32'(frame_done), 32'd0);
    chk("f1_count_held", 32'(motion_count), 32'd2);

    // Out-of-range pixels (x=400, y=250) are ignored.
    pix(9'd0, 8'd0, 1'b0);
    pix(9'd30, 8'd40, 1'b1);
    pix(9'd400, 8'd5, 1'b1);
    pix(9'd35, 8'd45, 1'b1);
    pix(9'd5, 8'd250, 1'b1);
    pix(9'd319, 8'd239, 1'b0);
    chk("oor_count", 32'(motion_count), 32'd2);
    chk_box("oor", 9'd30, 9'd35, 8'd40, 8'd45);

    // One motion pixel is below THRESH, so the box holds its previous value.
    pix(9'd0, 8'd0, 1'b0);
    pix(9'd60, 8'd70, 1'b1);
    pix(9'd319, 8'd239, 1'b0);
    chk("low_frame_done", 32'(frame_done), 32'd1);
    chk("low_valid", 32'(motion_valid), 32'd0);
    chk("low_count", 32'(motion_count), 32'd1);
    chk_box("low", 9'd30, 9'd35, 8'd40, 8'd45);

    // Motion on the first and last pixels gives the full-frame box.
    pix(9'd0, 8'd0, 1'b1);
    pix(9'd319, 8'd239, 1'b1);
    chk("corner_count", 32'(motion_count), 32'd2);
    chk("corner_valid", 32'(motion_valid), 32'd1);
    chk_box("corner", 9'd0, 9'd319, 8'd0, 8'd239);

    // With no (0,0) pixel, the frame still starts from cleared accumulators.
    pix(9'd8, 8'd9, 1'b1);
    pix(9'd12, 8'd3, 1'b1);
    pix(9'd319, 8'd239, 1'b0);
    chk("nostart_count", 32'(motion_count), 32'd2);
    chk_box("nostart", 9'd8, 9'd12, 8'd3, 8'd9);

    // Reset in mid-frame after 500 motion pixels, then a clean 3-pixel frame.
    pix(9'd0, 8'd0, 1'b0);
    for (int i = 0; i < 500; i++) pix(9'(i % 300), 8'd100, 1'b1);
    #3 resetn = 1'b0;
    #2;
    chk("midrst_count", 32'(motion_count), 32'd0);
    chk("midrst_valid", 32'(motion_valid), 32'd0);
    chk_box("midrst", 9'd0, 9'd0, 8'd0, 8'd0);
    chk("midrst_draw_plot", 32'(draw_plot), 32'd0);
    idle(2);
    resetn = 1'b1;
    fd_base = fd_cnt;
    idle(2);
    pix(9'd0, 8'd0, 1'b0);
    pix(9'd1, 8'd1, 1'b1);
    pix(9'd2, 8'd2, 1'b1);
    pix(9'd3, 8'd3, 1'b1);
    pix(9'd319, 8'd239, 1'b0);
    chk("postrst_count", 32'(motion_count), 32'd3);
    chk("postrst_valid", 32'(motion_valid), 32'd1);
    chk_box("postrst", 9'd1, 9'd3, 8'd1, 8'd3);
    idle(5);
    chk("postrst_one_done", 32'(fd_cnt - fd_base), 32'd1);
    idle(20);

    // Box 5..7 x 2..3 for the outline drawer.
    pix(9'd0, 8'd0, 1'b0);
    pix(9'd5, 8'd2, 1'b1);
    pix(9'd7, 8'd3, 1'b1);
    pix(9'd319, 8'd239, 1'b0);
    chk("draw_frame_done", 32'(frame_done), 32'd1);
    chk_box("draw", 9'd5, 9'd7, 8'd2, 8'd3);
    chk("draw_idle_plot", 32'(draw_plot), 32'd0);
`ifdef MOTION_BBOX_DRAW_EN
    for (int k = 0; k < 10; k++) begin
      @(negedge CLOCK_50);
      chk($sformatf("draw_plot_%0d", k), 32'(draw_plot), 32'd1);
      chk($sformatf("draw_x_%0d", k), 32'(draw_x), 32'(exp_dx[k]));
      chk($sformatf("draw_y_%0d", k), 32'(draw_y), 32'(exp_dy[k]));
    end
    @(negedge CLOCK_50);
    chk("draw_end_plot", 32'(draw_plot), 32'd0);
    idle(5);
`else
    idle(15);
    chk("nodraw_plot_cycles", 32'(dp_cnt), 32'd0);
    chk("nodraw_x", 32'(draw_x), 32'd0);
    chk("nodraw_y", 32'(draw_y), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
